palette_loader: RTL and testbench

PALETTE_LOADER -- requirements
Module: palette_loader

---
 rtl/palette_loader_pkg.sv | 26 ++
 rtl/palette_loader_sync_fifo.sv | 70 +++++++
 rtl/palette_loader.sv | 169 ++++++++++++++++
 tb/tb_palette_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_loader_pkg.sv
// Shared types and constants for the palette loader: FSM states, palette geometry
// and the RGB packing helper used when a third byte completes an entry.
package palette_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } pl_state_e;

    localparam int PAL_ENTRIES     = 64;
    localparam int BYTES_PER_ENTRY = 3;
    localparam int IDX_W           = 6;
    localparam int WORD_W          = 24;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAL_ENTRIES - 1);
    localparam logic [1:0]       PH_LAST  = 2'(BYTES_PER_ENTRY - 1);

    function automatic logic [WORD_W-1:0] pack_rgb(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/palette_loader_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding assembled palette words.
// A write into a full FIFO succeeds when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Qualify requests against the occupancy flags.
    always_comb begin
        do_rd_s = rd_en && (count_r != (AW + 1)'(0));
        do_wr_s = wr_en && ((count_r != DEPTH_C) || do_rd_s);
    end

    assign full    = (count_r == DEPTH_C);
    assign empty   = (count_r == (AW + 1)'(0));
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy, cleared by either reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/palette_loader.sv
// Assembles an R,G,B byte stream into 64 palette words and writes them to the
// palette RAM one per cycle, optionally only while the display is blanking.
module palette_loader
    import palette_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              hblank,
    input  logic              vblank,
    output logic              load_color,
    output logic [IDX_W-1:0]  load_color_index,
    output logic [WORD_W-1:0] load_color_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    pl_state_e         state_r, next_state_s;
    logic [1:0]        phase_r;
    logic [IDX_W-1:0]  push_cnt_r;
    logic [IDX_W-1:0]  wr_idx_r;
    logic [7:0]        r_byte_r, g_byte_r;
    logic              load_color_r, busy_r, done_r, error_r;
    logic [IDX_W-1:0]  index_r;
    logic [WORD_W-1:0] data_r;

    logic              fifo_full_s, fifo_empty_s;
    logic [WORD_W-1:0] fifo_rdata_s, fifo_wdata_s;
    logic              blank_ok_s, pop_s, ready_s, accept_s, push_s;
    logic              last_push_s, short_s;

    // Datapath handshakes. R and G bytes need no FIFO space, so only the B byte
    // waits on a full FIFO; start cancels any pop or byte in its cycle.
    always_comb begin
        blank_ok_s   = (BLANK_ONLY == 1'b0) || hblank || vblank;
        pop_s        = ((state_r == ST_LOAD) || (state_r == ST_DRAIN)) && !fifo_empty_s
                       && blank_ok_s && !start;
        ready_s      = (state_r == ST_LOAD) && !start
                       && ((phase_r != PH_LAST) || !fifo_full_s || pop_s);
        accept_s     = s_valid && ready_s;
        push_s       = accept_s && (phase_r == PH_LAST);
        last_push_s  = push_s && (push_cnt_r == LAST_IDX);
        short_s      = accept_s && s_last && !last_push_s;
        fifo_wdata_s = pack_rgb(r_byte_r, g_byte_r, s_data);
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_LOAD;
                else       next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (start)                       next_state_s = ST_LOAD;
                else if (last_push_s || short_s) next_state_s = ST_DRAIN;
                else                             next_state_s = ST_LOAD;
            end
            ST_DRAIN: begin
                if (start)                              next_state_s = ST_LOAD;
                else if (fifo_empty_s && !load_color_r) next_state_s = ST_FINISH;
                else                                    next_state_s = ST_DRAIN;
            end
            ST_FINISH: begin
                if (start) next_state_s = ST_LOAD;
                else       next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and status flags aligned with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_FINISH);
        end
    end

    // Byte assembly, push counting and the sticky short-stream flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r    <= 2'd0;
            push_cnt_r <= '0;
            r_byte_r   <= 8'd0;
            g_byte_r   <= 8'd0;
            error_r    <= 1'b0;
        end else if (start) begin
            phase_r    <= 2'd0;
            push_cnt_r <= '0;
            error_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                if (short_s || (phase_r == PH_LAST)) begin
                    phase_r <= 2'd0;
                end else begin
                    phase_r <= phase_r + 2'd1;
                end
                if (phase_r == 2'd0) r_byte_r <= s_data;
                if (phase_r == 2'd1) g_byte_r <= s_data;
            end
            if (push_s && (push_cnt_r != LAST_IDX)) begin
                push_cnt_r <= push_cnt_r + IDX_W'(1);
            end
            if (short_s) begin
                error_r <= 1'b1;
            end
        end
    end

    // Palette write port: a pop registers one write; index and data hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_color_r <= 1'b0;
            index_r      <= '0;
            data_r       <= '0;
            wr_idx_r     <= '0;
        end else begin
            load_color_r <= pop_s;
            if (pop_s) begin
                index_r <= wr_idx_r;
                data_r  <= fifo_rdata_s;
            end
            if (start) begin
                wr_idx_r <= '0;
            end else if (pop_s && (wr_idx_r != LAST_IDX)) begin
                wr_idx_r <= wr_idx_r + IDX_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .srst    (start),
        .wr_en   (push_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (pop_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign s_ready          = ready_s;
    assign load_color       = load_color_r;
    assign load_color_index = index_r;
    assign load_color_data  = data_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign error            = error_r;

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: expected palette writes are queued as each
// entry's third byte is handed over and checked when load_color appears.
module tb_palette_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        hblank;
    logic        vblank = 1'b0;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic        busy, done, error;

    logic        hblank_drv = 1'b0;
    logic        hb_tog = 1'b1;
    logic        tog_en = 1'b0;
    assign hblank = tog_en ? hb_tog : hblank_drv;

    typedef struct {
        logic [5:0]  idx;
        logic [23:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         exp_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    int          n_done = 0;
    logic        prev_blank = 1'b0;
    logic [23:0] entry5 = 24'd0;

    palette_loader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .hblank           (hblank),
        .vblank           (vblank),
        .load_color       (load_color),
        .load_color_index (load_color_index),
        .load_color_data  (load_color_data),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bval(input int i, input int seed);
        return 8'((i * 7) + (seed * 31) + 3);
    endfunction

    function automatic logic [23:0] word(input int e, input int seed);
        return {bval(3 * e, seed), bval(3 * e + 1, seed), bval(3 * e + 2, seed)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every load_color must match the scoreboard head and follow blanking.
    always @(negedge clk) begin
        if (reset_n) begin
            if (load_color) begin
                n_writes++;
                chk("blank_gate", {31'd0, prev_blank}, 32'd1);
                if (sb.size() == 0) begin
                    chk("write_with_empty_scoreboard", sb.size(), 32'd1);
                end else begin
                    exp_e = sb.pop_front();
                    chk("wr_index", {26'd0, load_color_index}, {26'd0, exp_e.idx});
                    chk("wr_data", {8'd0, load_color_data}, {8'd0, exp_e.data});
                end
                if (load_color_index == 6'd5) entry5 = load_color_data;
            end
            if (done) n_done++;
        end
        prev_blank = hblank | vblank;
    end

    // Independent hblank pattern: 4 cycles on, 4 cycles off.
    initial begin
        int tog_cnt;
        tog_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                tog_cnt++;
                if (tog_cnt == 4) begin
                    hb_tog = ~hb_tog;
                    tog_cnt = 0;
                end
            end else begin
                tog_cnt = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input int first, input int count, input int seed, input int last_at);
        bit r;
        bit ok;
        int waited;
        for (int i = first; i < first + count; i++) begin
            s_valid = 1'b1;
            s_data  = bval(i, seed);
            s_last  = (i + 1 == last_at);
            ok = 1'b0;
            waited = 0;
            while (!ok && waited < 200) begin
                @(negedge clk);
                r = s_ready;
                @(posedge clk);
                #1;
                if (r) ok = 1'b1;
                else   waited++;
            end
            if (!ok) begin
                chk("handshake_timeout", {31'd0, ok}, 32'd1);
                break;
            end
            if ((i % 3) == 2) sb.push_back('{idx: 6'(i / 3), data: word(i / 3, seed)});
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk(tag, {31'd0, got}, 32'd1);
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_load_color"}, {31'd0, load_color}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_index"}, {26'd0, load_color_index}, 32'd0);
        chk({tag, "_data"}, {8'd0, load_color_data}, 32'd0);
    endtask

    initial begin
        int wb;
        int db;
        int acc;
        bit r;

        // Reset values
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1 reset_n = 1'b1;

        // Full load with constant blanking
        hblank_drv = 1'b1;
        wb = n_writes;
        pulse_start();
        @(negedge clk);
        chk("full_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        send(0, 192, 1, 0);
        wait_done("full_done", 100);
        chk("full_writes", n_writes - wb, 32'd64);
        chk("full_entry5", {8'd0, entry5}, {8'd0, bval(15, 1), bval(16, 1), bval(17, 1)});
        chk("full_error", {31'd0, error}, 32'd0);
        chk("full_sb_empty", sb.size(), 32'd0);

        // Short stream: s_last on byte 10 (partial word discarded)
        wb = n_writes;
        pulse_start();
        send(0, 10, 2, 10);
        wait_done("short10_done", 100);
        chk("short10_writes", n_writes - wb, 32'd3);
        chk("short10_error", {31'd0, error}, 32'd1);

        // Short stream: s_last on byte 9 (completed word still written)
        wb = n_writes;
        pulse_start();
        @(negedge clk);
        chk("start_clears_error", {31'd0, error}, 32'd0);
        @(posedge clk); #1;
        send(0, 9, 3, 9);
        wait_done("short9_done", 100);
        chk("short9_writes", n_writes - wb, 32'd3);
        chk("short9_error", {31'd0, error}, 32'd1);

        // Blank gating with hblank toggling
        wb = n_writes;
        hb_tog = 1'b1;
        tog_en = 1'b1;
        pulse_start();
        send(0, 192, 4, 0);
        wait_done("gate_done", 200);
        chk("gate_writes", n_writes - wb, 32'd64);
        tog_en = 1'b0;

        // Back-pressure: no blanking for 100 cycles
        hblank_drv = 1'b0;
        wb = n_writes;
        pulse_start();
        acc = 0;
        s_valid = 1'b1;
        s_data = bval(0, 5);
        repeat (100) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) begin
                if ((acc % 3) == 2) sb.push_back('{idx: 6'(acc / 3), data: word(acc / 3, 5)});
                acc++;
                s_data = bval(acc, 5);
            end
        end
        chk("bp_bytes", acc, 32'd14);
        @(negedge clk);
        chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
        chk("bp_no_writes", n_writes - wb, 32'd0);
        @(posedge clk); #1 hblank_drv = 1'b1;
        send(acc, 192 - acc, 5, 0);
        wait_done("bp_done", 100);
        chk("bp_writes", n_writes - wb, 32'd64);

        // Restart at byte 90 with words still queued
        pulse_start();
        send(0, 81, 6, 0);
        hblank_drv = 1'b0;
        send(81, 9, 6, 0);
        repeat (2) @(posedge clk);
        #1;
        db = n_done;
        sb.delete();
        wb = n_writes;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("restart_no_write", n_writes - wb, 32'd0);
        chk("restart_no_done", n_done - db, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 vblank = 1'b1;
        send(0, 192, 7, 0);
        wait_done("restart_done", 100);
        chk("restart_writes", n_writes - wb, 32'd64);
        chk("restart_done_count", n_done - db, 32'd1);
        chk("restart_error", {31'd0, error}, 32'd0);

        // Reset while draining with words stalled in the FIFO
        vblank = 1'b0;
        hblank_drv = 1'b0;
        pulse_start();
        send(0, 6, 8, 6);
        repeat (3) @(negedge clk);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        chk("drain_error", {31'd0, error}, 32'd1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        sb.delete();
        wb = n_writes;
        @(posedge clk); #1 reset_n = 1'b1;
        hblank_drv = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_no_writes", n_writes - wb, 32'd0);
        check_idle_outputs("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
